chess_clock_ctrl: RTL

- Two-player chess-clock scheduler for the timer/seven-segment peripheral.
- Sequences two countdown timers held in BCD mm:ss format. Only the active player's timer runs.
- On a turn switch, applies a Fischer increment one second per cycle to the player who just moved.
- Time-multiplexes the active player's time onto a 4-digit seven-segment display. Control inputs come from the AXI4-Lite register bank.

---
 rtl/chess_clock_pkg.sv | 87 ++++++++
 rtl/chess_clock_ctrl_if.sv | 32 +++
 rtl/chess_clock_ctrl_seg7_decode.sv | 28 ++
 rtl/chess_clock_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/chess_clock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chess_clock_pkg                                                            |
// | Shared state encoding, BCD time type and BCD arithmetic helpers.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package chess_clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_INC     = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_TIMEOUT = 3'd4
  } cc_state_t;

  typedef struct packed {
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
  } bcd_time_t;

  localparam logic [15:0] TIME_MAX = 16'h9959;
  localparam logic [5:0]  INC_MAX  = 6'd59;

  // Forces every digit into its legal range so the timers only ever hold valid BCD.
  function automatic bcd_time_t bcd_clamp(input logic [15:0] raw);
    bcd_time_t t;
    t = raw;
    if (t.m10 > 4'd9) t.m10 = 4'd9;
    if (t.m1  > 4'd9) t.m1  = 4'd9;
    if (t.s10 > 4'd5) t.s10 = 4'd5;
    if (t.s1  > 4'd9) t.s1  = 4'd9;
    return t;
  endfunction

  function automatic bcd_time_t bcd_dec1(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t != '0) begin
      if (t.s1 != 4'd0) begin
        r.s1 = t.s1 - 4'd1;
      end else begin
        r.s1 = 4'd9;
        if (t.s10 != 4'd0) begin
          r.s10 = t.s10 - 4'd1;
        end else begin
          r.s10 = 4'd5;
          if (t.m1 != 4'd0) begin
            r.m1 = t.m1 - 4'd1;
          end else begin
            r.m1  = 4'd9;
            r.m10 = t.m10 - 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic bcd_time_t bcd_inc1_sat(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t != TIME_MAX) begin
      if (t.s1 < 4'd9) begin
        r.s1 = t.s1 + 4'd1;
      end else begin
        r.s1 = 4'd0;
        if (t.s10 < 4'd5) begin
          r.s10 = t.s10 + 4'd1;
        end else begin
          r.s10 = 4'd0;
          if (t.m1 < 4'd9) begin
            r.m1 = t.m1 + 4'd1;
          end else begin
            r.m1  = 4'd0;
            r.m10 = t.m10 + 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chess_clock_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chess_clock_ctrl_if                                                        |
// | Register-bank side of the chess clock: configuration, commands, status.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface chess_clock_ctrl_if;
  logic        cfg_load;
  logic [15:0] cfg_time;
  logic [5:0]  cfg_inc;
  logic        cmd_start;
  logic        cmd_switch;
  logic        cmd_pause;
  logic [2:0]  state;
  logic        active_player;
  logic [15:0] time_w;
  logic [15:0] time_b;
  logic        flag_w;
  logic        flag_b;
  logic        irq;

  modport master (
    output cfg_load, cfg_time, cfg_inc, cmd_start, cmd_switch, cmd_pause,
    input  state, active_player, time_w, time_b, flag_w, flag_b, irq
  );

  modport slave (
    input  cfg_load, cfg_time, cfg_inc, cmd_start, cmd_switch, cmd_pause,
    output state, active_player, time_w, time_b, flag_w, flag_b, irq
  );
endinterface
`default_nettype wire

// File: rtl/chess_clock_ctrl_seg7_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_decode                                                                |
// | BCD digit to active-low seven-segment pattern {g..a}; non-BCD is blank.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seg7_decode (
  input  wire logic [3:0] digit,
  output logic      [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (digit)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/chess_clock_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chess_clock_ctrl                                                           |
// | Two-player BCD countdown clock with Fischer increment and 4-digit display. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module chess_clock_ctrl
  import chess_clock_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int SCAN_DIV    = 100000
) (
  input  wire logic        ACLK,
  input  wire logic        ARESETN,
  chess_clock_ctrl_if.slave bus,
  output logic      [3:0]  seg_an,
  output logic      [6:0]  seg_cat
);

  localparam int c_PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam int c_SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(CLK_FREQ_HZ - 1);
  localparam logic [c_SW-1:0] c_SCAN_MAX  = c_SW'(SCAN_DIV - 1);

  cc_state_t       r_state, w_next_state;
  logic [c_PW-1:0] r_presc;
  logic [5:0]      r_inc_cnt;
  logic            r_active;
  bcd_time_t       r_time_w, r_time_b;
  logic            r_flag_w, r_flag_b, r_irq;

  logic [c_SW-1:0] r_scan;
  logic [1:0]      r_digit_idx;
  logic            r_scan_live;
  logic [3:0]      r_seg_an;
  logic [6:0]      r_seg_cat;

  bcd_time_t  w_active_time, w_dec_time, w_inc_time, w_cfg_time;
  logic [5:0] w_cfg_inc;
  logic       w_tick, w_both_set;
  logic       w_do_load, w_do_start, w_do_resume, w_do_tick, w_do_timeout;
  logic       w_do_switch, w_do_pause, w_do_toggle, w_do_inc_enter, w_do_inc_step;
  logic [3:0] w_digit;
  logic [6:0] w_digit_seg;

  assign w_active_time = r_active ? r_time_b : r_time_w;
  assign w_dec_time    = bcd_dec1(w_active_time);
  assign w_inc_time    = bcd_inc1_sat(w_active_time);
  assign w_cfg_time    = bcd_clamp(bus.cfg_time);
  assign w_cfg_inc     = (bus.cfg_inc > INC_MAX) ? INC_MAX : bus.cfg_inc;
  assign w_tick        = (r_presc == c_PRESC_MAX);
  assign w_both_set    = (r_time_w != '0) && (r_time_b != '0);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_PAUSED, ST_TIMEOUT: begin
        if (w_do_load)                      w_next_state = ST_IDLE;
        else if (w_do_start || w_do_resume) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (w_do_timeout)        w_next_state = ST_TIMEOUT;
        else if (w_do_inc_enter) w_next_state = ST_INC;
        else if (w_do_pause)     w_next_state = ST_PAUSED;
      end
      ST_INC: begin
        if (w_do_toggle) w_next_state = ST_RUN;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Decodes the state and commands into datapath strobes, applying the
  // timeout > switch > pause priority within RUN.
  always_comb begin
    w_do_load      = 1'b0;
    w_do_start     = 1'b0;
    w_do_resume    = 1'b0;
    w_do_tick      = 1'b0;
    w_do_timeout   = 1'b0;
    w_do_switch    = 1'b0;
    w_do_pause     = 1'b0;
    w_do_toggle    = 1'b0;
    w_do_inc_enter = 1'b0;
    w_do_inc_step  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_do_load  = bus.cfg_load;
        w_do_start = !bus.cfg_load && bus.cmd_start && w_both_set;
      end
      ST_PAUSED: begin
        w_do_load   = bus.cfg_load;
        w_do_resume = !bus.cfg_load && bus.cmd_start;
      end
      ST_TIMEOUT: begin
        w_do_load = bus.cfg_load;
      end
      ST_RUN: begin
        w_do_tick      = w_tick;
        w_do_timeout   = w_tick && (w_dec_time == '0);
        w_do_switch    = !w_do_timeout && bus.cmd_switch;
        w_do_pause     = !w_do_timeout && !bus.cmd_switch && bus.cmd_pause;
        w_do_toggle    = w_do_switch && (w_cfg_inc == 6'd0);
        w_do_inc_enter = w_do_switch && (w_cfg_inc != 6'd0);
      end
      ST_INC: begin
        w_do_inc_step = 1'b1;
        w_do_toggle   = (r_inc_cnt <= 6'd1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_presc   <= '0;
      r_inc_cnt <= '0;
      r_active  <= 1'b0;
      r_time_w  <= '0;
      r_time_b  <= '0;
      r_flag_w  <= 1'b0;
      r_flag_b  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      if (w_do_load) begin
        r_time_w <= w_cfg_time;
        r_time_b <= w_cfg_time;
        r_flag_w <= 1'b0;
        r_flag_b <= 1'b0;
        r_active <= 1'b0;
        r_presc  <= '0;
      end
      if (w_do_start) r_presc <= '0;
      if (r_state == ST_RUN) begin
        if (w_tick)           r_presc <= '0;
        else if (!w_do_pause) r_presc <= r_presc + c_PW'(1);
      end
      if (w_do_tick) begin
        if (r_active) r_time_b <= w_dec_time;
        else          r_time_w <= w_dec_time;
      end
      if (w_do_inc_step) begin
        if (r_active) r_time_b <= w_inc_time;
        else          r_time_w <= w_inc_time;
        r_inc_cnt <= r_inc_cnt - 6'd1;
      end
      if (w_do_timeout) begin
        if (r_active) r_flag_b <= 1'b1;
        else          r_flag_w <= 1'b1;
        r_irq <= 1'b1;
      end
      if (w_do_inc_enter) r_inc_cnt <= w_cfg_inc;
      if (w_do_toggle) begin
        r_active <= ~r_active;
        r_presc  <= '0;
      end
    end
  end

  always_comb begin
    w_digit = w_active_time.s1;
    case (r_digit_idx)
      2'd0: w_digit = w_active_time.s1;
      2'd1: w_digit = w_active_time.s10;
      2'd2: w_digit = w_active_time.m1;
      2'd3: w_digit = w_active_time.m10;
      default: w_digit = w_active_time.s1;
    endcase
  end

  seg7_decode u_seg7_decode (
    .digit (w_digit),
    .seg   (w_digit_seg)
  );

  // Segments stay dark until the first scan slot has elapsed after reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_scan      <= '0;
      r_digit_idx <= 2'd0;
      r_scan_live <= 1'b0;
      r_seg_an    <= 4'hF;
      r_seg_cat   <= 7'h7F;
    end else begin
      if (r_scan == c_SCAN_MAX) begin
        r_scan      <= '0;
        r_digit_idx <= r_digit_idx + 2'd1;
        r_scan_live <= 1'b1;
      end else begin
        r_scan <= r_scan + c_SW'(1);
      end
      if (r_scan_live) begin
        r_seg_an  <= ~(4'b0001 << r_digit_idx);
        r_seg_cat <= w_digit_seg;
      end
    end
  end

  assign bus.state         = r_state;
  assign bus.active_player = r_active;
  assign bus.time_w        = r_time_w;
  assign bus.time_b        = r_time_b;
  assign bus.flag_w        = r_flag_w;
  assign bus.flag_b        = r_flag_b;
  assign bus.irq           = r_irq;
  assign seg_an            = r_seg_an;
  assign seg_cat           = r_seg_cat;

endmodule
`default_nettype wire
